// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central hazard controller for the five-stage pipeline.
// Resolves data hazards between the ID instruction and the producers in
// E/M/W, selects operand forwarding sources, tracks multiply/divide
// occupancy of the HI/LO unit and keeps a saturating stall statistic.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs_addr,
    input  logic [4:0]       id_rt_addr,
    input  logic [3:0]       id_rs_use,
    input  logic [3:0]       id_rt_use,
    input  logic [1:0]       id_md_op,
    input  logic [4:0]       ex_dst_addr,
    input  logic [4:0]       mem_dst_addr,
    input  logic [4:0]       wb_dst_addr,
    input  logic [3:0]       ex_dst_save,
    input  logic [3:0]       mem_dst_save,
    input  logic [3:0]       wb_dst_save,
    input  logic [1:0]       ex_md_start,
    output logic             if_enable,
    output logic             id_flush,
    output logic [1:0]       fwd_rs_sel,
    output logic [1:0]       fwd_rt_sel,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_count
);

    localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int MD_W   = $clog2(MD_MAX + 1);

    localparam logic [MD_W-1:0]  MULT_LOAD = MD_W'(MULT_CYCLES);
    localparam logic [MD_W-1:0]  DIV_LOAD  = MD_W'(DIV_CYCLES);
    localparam logic [MD_W-1:0]  MD_ZERO   = {MD_W{1'b0}};
    localparam logic [MD_W-1:0]  MD_ONE    = MD_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Resolve one source operand against E/M/W.
    // Returns {stall, fwd_sel}. The nearest matching producer wins
    // (E before M before W); $0 and unused operands (use == 4) never match.
    function automatic logic [2:0] resolve_src(
        input logic [4:0] src_addr,
        input logic [3:0] src_use,
        input logic [4:0] e_addr,
        input logic [3:0] e_save,
        input logic [4:0] m_addr,
        input logic [3:0] m_save,
        input logic [4:0] w_addr,
        input logic [3:0] w_save
    );
        logic       active;
        logic [1:0] stage;
        logic [3:0] save;
        logic       stall;
        logic [1:0] sel;
        active = (src_addr != 5'd0) && (src_use != 4'd4);
        if (active && (src_addr == e_addr)) begin
            stage = 2'b01;
            save  = e_save;
        end else if (active && (src_addr == m_addr)) begin
            stage = 2'b10;
            save  = m_save;
        end else if (active && (src_addr == w_addr)) begin
            stage = 2'b11;
            save  = w_save;
        end else begin
            stage = 2'b00;
            save  = 4'd0;
        end
        stall = (stage != 2'b00) && (save > src_use);
        if ((stage != 2'b00) && (save == 4'd0)) begin
            sel = stage;
        end else begin
            sel = 2'b00;
        end
        return {stall, sel};
    endfunction

    logic [2:0]       rs_res_s;
    logic [2:0]       rt_res_s;
    logic             data_stall_s;
    logic             md_start_s;
    logic             md_stall_s;
    logic             stall_s;
    logic [MD_W-1:0]  md_cnt_r;
    logic [CNT_W-1:0] stall_cnt_r;

    // Data hazard resolution for both source operands and the combined stall.
    always_comb begin
        rs_res_s = resolve_src(id_rs_addr, id_rs_use,
                               ex_dst_addr, ex_dst_save,
                               mem_dst_addr, mem_dst_save,
                               wb_dst_addr, wb_dst_save);
        rt_res_s = resolve_src(id_rt_addr, id_rt_use,
                               ex_dst_addr, ex_dst_save,
                               mem_dst_addr, mem_dst_save,
                               wb_dst_addr, wb_dst_save);
        data_stall_s = rs_res_s[2] | rt_res_s[2];
        md_start_s   = (ex_md_start == 2'b01) || (ex_md_start == 2'b10);
        md_stall_s   = (id_md_op != 2'b00) && ((md_cnt_r != MD_ZERO) || md_start_s);
        stall_s      = data_stall_s | md_stall_s;
    end

    // Drive the pipeline control outputs from the resolved hazard state.
    always_comb begin
        if_enable  = ~stall_s;
        id_flush   = stall_s;
        fwd_rs_sel = rs_res_s[1:0];
        fwd_rt_sel = rt_res_s[1:0];
        md_busy    = (md_cnt_r != MD_ZERO);
    end

    // Multiply/divide occupancy counter: load on issue in E, else count down.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt_r <= MD_ZERO;
        end else begin
            case (ex_md_start)
                2'b01:   md_cnt_r <= MULT_LOAD;
                2'b10:   md_cnt_r <= DIV_LOAD;
                default: begin
                    if (md_cnt_r != MD_ZERO) begin
                        md_cnt_r <= md_cnt_r - MD_ONE;
                    end else begin
                        md_cnt_r <= md_cnt_r;
                    end
                end
            endcase
        end
    end

    // Saturating count of cycles in which the front end was held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_count = stall_cnt_r;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Central hazard controller for the five-stage pipeline. It compares the operand-use timing (`rs_use`/`rt_use`) of the instruction in ID with the result-ready timing (`dst_save`) and destination address of the instructions in E, M and W. From this it generates the stall enable for the PC/IF register, the bubble request for the ID/EX register, and the operand forwarding selects. It also runs the multiply/divide busy counter, which stalls HI/LO-dependent instructions, and counts stall cycles for performance analysis.

## Interface
Parameters:
- `MULT_CYCLES`, 5, busy duration of a mult-class operation
- `DIV_CYCLES`, 10, busy duration of a div-class operation
- `CNT_W`, 32, width of the stall statistics counter

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `id_rs_addr`, `id_rt_addr`  in  5 each  source register addresses of the ID instruction
- `id_rs_use`, `id_rt_use`  in  4 each  cycles until the operand is needed; 4 = operand unused
- `id_md_op`  in  2  ID HI/LO class: 00 none, 01 mult start, 10 div start, 11 mfhi/mflo/mthi/mtlo
- `ex_dst_addr`, `mem_dst_addr`, `wb_dst_addr`  in  5 each  destination register per stage
- `ex_dst_save`, `mem_dst_save`, `wb_dst_save`  in  4 each  cycles until the result is ready, as already decremented at stage output
- `ex_md_start`  in  2  E-stage issue: 01 mult, 10 div, 00/11 none
- `if_enable`  out  1  enable for PC and IF/ID register; 0 = hold
- `id_flush`  out  1  forces a bubble (all-zero, use=4) into ID/EX
- `fwd_rs_sel`, `fwd_rt_sel`  out  2 each  forwarding source: 00 GRF, 01 E, 10 M, 11 W
- `md_busy`  out  1  multiply/divide unit busy
- `stall_count`  out  `CNT_W`  saturating count of stalled cycles

## Operation
- **Producer match.** Stage X matches a source when `addr != 0`, `addr == X_dst_addr`, and use != 4. Register $0 never matches.
- **Nearest producer.** Only the nearest matching stage counts, with priority E > M > W.
- **Data stall.** A source stalls when its nearest producer has `dst_save > use`. `data_stall` is the OR of the rs and rt terms.
- **Forwarding.** `fwd_*_sel` selects the nearest matching stage only when that stage has `dst_save == 0`; otherwise it is 00. Forwarding is computed even during a stall, because ID/EX is flushed anyway.
- **MD counter.**
  - Counter width: ceil(log2(max(MULT_CYCLES, DIV_CYCLES) + 1)).
  - When `ex_md_start` is 01 or 10, the counter loads `MULT_CYCLES` or `DIV_CYCLES` respectively. Otherwise it decrements when nonzero.
  - `md_busy` = (counter != 0).
- **MD stall.** Asserted when `id_md_op != 00` and (`md_busy` or `ex_md_start` is 01/10).
- **Stall.** `stall = data_stall | md_stall`. Then `if_enable = ~stall` and `id_flush = stall`.
- **Stall count.** `stall_count` increments on every clock edge where `stall` = 1 and saturates at all-ones.
- **Start while busy.** A new `ex_md_start` while busy reloads the counter. ID-side md stalling keeps this from occurring legally; the case is defined for robustness only.

## Timing
- Stall and forwarding outputs are combinational from their inputs within the same cycle. There is no registered latency.
- MD start in E at edge N loads the counter. `md_busy` is high for exactly `MULT_CYCLES`/`DIV_CYCLES` cycles after edge N.
- The md stall term covers the E-issue cycle plus every busy cycle. An ID md instruction is released in the first cycle with counter == 0 and no start in E.
- **Reset** (`reset` = 0, asynchronous):
  - MD counter = 0, so `md_busy` = 0.
  - `stall_count` = 0.
  - Combinational outputs follow their inputs. With reset-state pipeline registers (addr 0, use 4), these are `if_enable` = 1, `id_flush` = 0, `fwd_*_sel` = 00.
- **Reset mid-operation.** Asserting reset during a div clears busy immediately, without waiting for a clock edge. Deassertion takes effect on the next rising edge.
- **Simultaneous events.**
  - A data stall and an md stall together count once in `stall_count`.
  - rs and rt both forwarding from different stages is legal and independent.

## Test plan
- **Load-use stall.** E: addr 5, save 2; ID: rs 5, use 0 -> `if_enable` = 0, `id_flush` = 1, `stall_count` increments by 1 per cycle; releases when save ≤ use.
- **Forwarding.**
  - M: addr 5, save 0; ID: rs 5, use 1 -> `fwd_rs_sel` = 10, no stall.
  - E and M both addr 5, both save 0 -> `fwd_rs_sel` = 01.
- **Register $0 and unused operands.**
  - ID rs = 0 with E addr 0, save 3 -> no stall, `fwd_rs_sel` = 00.
  - use = 4 with a matching E producer -> no stall.
- **Mult busy.** `ex_md_start` = 01 at edge 0 while ID `md_op` = 11 -> `md_busy` is high for 5 cycles; stall holds through the busy window; `if_enable` returns to 1 in the cycle after the counter reaches 0; `stall_count` = 6.
- **Reset mid-div.** Start a div, then pull `reset` low 3 cycles later -> `md_busy` = 0 and `stall_count` = 0 asynchronously; after release the counter stays 0.
- **Saturation.** With `CNT_W` = 4, hold a stall for 20 cycles -> `stall_count` = 15 and holds at 15.
